stage2_pow2_ratio: RTL and testbench

STAGE2_POW2_RATIO -- requirements
Module: stage2_pow2_ratio

---
 rtl/stage2_pow2_ratio.sv | 99 +++++++++
 tb/tb_stage2_pow2_ratio.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stage2_pow2_ratio.sv
// stage2_pow2_ratio: Mitchell log2 of in1, subtract log2(in0), then exp2 back to a Q6.10 ratio in1/in0
module stage2_pow2_ratio #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_log2_in0,
   input  logic [DATA_W-1:0] i_in0_byp,
   input  logic [DATA_W-1:0] i_in1_byp,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_ratio,
   output logic              o_sat,
   output logic              o_div0,
   output logic [DATA_W-1:0] o_in0_byp,
   output logic [DATA_W-1:0] o_in1_byp
);
   localparam int PW = $clog2(DATA_W);
   localparam int DW = DATA_W + 1;
   localparam int IW = DW - FRAC_W;
   localparam logic [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
   logic              va_q, va_d, z0a_q, z0a_d, z1a_q, z1a_d;
   logic [DW-1:0]     l1_q, l1_d;
   logic [DATA_W-1:0] lg_q, lg_d, in0a_q, in0a_d, in1a_q, in1a_d;
   logic              vb_q, vb_d, z0b_q, z0b_d, z1b_q, z1b_d;
   logic [IW-1:0]     ib_q, ib_d;
   logic [FRAC_W-1:0] fb_q, fb_d;
   logic [DATA_W-1:0] in0b_q, in0b_d, in1b_q, in1b_d;
   logic              vc_q, vc_d, sat_q, sat_d, div0_q, div0_d;
   logic [DATA_W-1:0] ratio_q, ratio_d, in0c_q, in0c_d, in1c_q, in1c_d;
   logic [PW-1:0]     p;
   logic [FRAC_W-1:0] frac;
   logic [DW-1:0]     d;
   logic [DATA_W-1:0] mant;
   logic [IW-1:0]     nib;
   logic              sat_i, under;

   // Stage A: leading-one search and Mitchell log2 of in1, sign/zero flags
   always_comb begin
      p = '0;
      for (int k = 0; k < DATA_W - 1; k++) if (i_in1_byp[k]) p = k[PW-1:0];
      frac = FRAC_W'((i_in1_byp << (DATA_W - 2 - int'(p))) >> (DATA_W - 2 - FRAC_W));
      l1_d = ((DW'(p) - DW'(FRAC_W)) << FRAC_W) + DW'(frac);
      va_d = i_valid;
      z0a_d = i_in0_byp[DATA_W-1] || i_in0_byp == '0;
      z1a_d = i_in1_byp[DATA_W-1] || i_in1_byp == '0;
      lg_d = i_log2_in0;
      in0a_d = i_in0_byp;
      in1a_d = i_in1_byp;
   end

   // Stage B: log-domain difference split into integer exponent and fraction
   always_comb begin
      d = l1_q - {lg_q[DATA_W-1], lg_q};
      ib_d = d[DW-1:FRAC_W];
      fb_d = d[FRAC_W-1:0];
      vb_d = va_q;
      z0b_d = z0a_q;
      z1b_d = z1a_q;
      in0b_d = in0a_q;
      in1b_d = in1a_q;
   end

   // Stage C: exp2 via shifted (1+f) mantissa with zero/saturation overrides
   always_comb begin
      mant = DATA_W'({1'b1, fb_q});
      nib = -ib_q;
      sat_i = int'($signed(ib_q)) >= DATA_W - 1 - FRAC_W;
      under = int'($signed(ib_q)) <= -(FRAC_W + 1);
      ratio_d = z1b_q ? '0 : (z0b_q || sat_i) ? MAX : under ? '0 : ib_q[IW-1] ? mant >> nib : mant << ib_q;
      sat_d = !z1b_q && (z0b_q || sat_i);
      div0_d = z0b_q;
      vc_d = vb_q;
      in0c_d = in0b_q;
      in1c_d = in1b_q;
   end

   // Pipeline registers: reset clears everything, otherwise advance only when enabled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         va_q <= 1'b0; z0a_q <= 1'b0; z1a_q <= 1'b0; l1_q <= '0; lg_q <= '0; in0a_q <= '0; in1a_q <= '0;
         vb_q <= 1'b0; z0b_q <= 1'b0; z1b_q <= 1'b0; ib_q <= '0; fb_q <= '0; in0b_q <= '0; in1b_q <= '0;
         vc_q <= 1'b0; sat_q <= 1'b0; div0_q <= 1'b0; ratio_q <= '0; in0c_q <= '0; in1c_q <= '0;
      end else if (i_en) begin
         va_q <= va_d; z0a_q <= z0a_d; z1a_q <= z1a_d; l1_q <= l1_d; lg_q <= lg_d; in0a_q <= in0a_d; in1a_q <= in1a_d;
         vb_q <= vb_d; z0b_q <= z0b_d; z1b_q <= z1b_d; ib_q <= ib_d; fb_q <= fb_d; in0b_q <= in0b_d; in1b_q <= in1b_d;
         vc_q <= vc_d; sat_q <= sat_d; div0_q <= div0_d; ratio_q <= ratio_d; in0c_q <= in0c_d; in1c_q <= in1c_d;
      end
   end

   assign o_valid = vc_q;
   assign o_ratio = ratio_q;
   assign o_sat = sat_q;
   assign o_div0 = div0_q;
   assign o_in0_byp = in0c_q;
   assign o_in1_byp = in1c_q;
endmodule

// File: tb/tb_stage2_pow2_ratio.sv
// tb_stage2_pow2_ratio: vector table plus scoreboard bench for the pow2 ratio stage
module tb_stage2_pow2_ratio;
   logic i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b0, i_valid = 1'b0;
   logic [15:0] i_log2_in0 = '0, i_in0_byp = '0, i_in1_byp = '0;
   logic o_valid, o_sat, o_div0;
   logic [15:0] o_ratio, o_in0_byp, o_in1_byp;

   typedef struct {logic [15:0] in0, in1, ratio; logic sat, div0; int tag;} exp_t;
   typedef struct {logic [15:0] in0, lg, in1, ratio; logic sat, div0;} vec_t;

   exp_t sb[$];
   exp_t cur;
   vec_t tv[$];
   int total = 0, bad = 0, en_edges = 0;

   stage2_pow2_ratio dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
      .i_log2_in0(i_log2_in0), .i_in0_byp(i_in0_byp), .i_in1_byp(i_in1_byp),
      .o_valid(o_valid), .o_ratio(o_ratio), .o_sat(o_sat), .o_div0(o_div0),
      .o_in0_byp(o_in0_byp), .o_in1_byp(o_in1_byp)
   );

   always #5 i_clk = ~i_clk;

   function automatic exp_t model(logic [15:0] a, logic [15:0] lg, logic [15:0] b);
      exp_t e;
      int p, fr, l1, d, f, ii, m;
      e.in0 = a; e.in1 = b; e.tag = 0; e.sat = 1'b0; e.ratio = '0;
      e.div0 = $signed(a) <= 0;
      if ($signed(b) <= 0) return e;
      if (e.div0) begin
         e.ratio = 16'h7fff; e.sat = 1'b1; return e;
      end
      p = 14;
      while (!b[p]) p--;
      fr = ((int'(b) - (1 << p)) * 1024) >> p;
      l1 = (p - 10) * 1024 + fr;
      d = l1 - int'($signed(lg));
      f = d & 1023;
      ii = (d - f) / 1024;
      if (ii >= 5) begin
         e.ratio = 16'h7fff; e.sat = 1'b1;
      end else if (ii > -11) begin
         m = 1024 + f;
         e.ratio = 16'(ii >= 0 ? m << ii : m >> (-ii));
      end
      return e;
   endfunction

   function automatic logic [50:0] outs();
      return {o_valid, o_ratio, o_sat, o_div0, o_in0_byp, o_in1_byp};
   endfunction

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic drive(logic v, logic [15:0] a, logic [15:0] lg, logic [15:0] b);
      i_valid = v; i_in0_byp = a; i_log2_in0 = lg; i_in1_byp = b;
      cur = model(a, lg, b);
   endtask

   // One clock: push what this edge samples, then check what the DUT shows after it
   task automatic step();
      logic was_en, was_rst, exp_v;
      logic [50:0] snap;
      exp_t e;
      was_en = i_en; was_rst = i_rst; snap = outs();
      if (!was_rst && was_en && i_valid) begin
         e = cur; e.tag = en_edges; sb.push_back(e);
      end
      @(posedge i_clk);
      #1;
      if (was_rst) begin
         sb.delete();
         chk("reset_clear", 64'(outs()), 64'(0));
      end else if (!was_en) begin
         chk("stall_hold", 64'(outs()), 64'(snap));
      end else begin
         en_edges++;
         exp_v = sb.size() > 0 && sb[0].tag + 3 == en_edges;
         chk("valid", 64'(o_valid), 64'(exp_v));
         if (exp_v || (o_valid && sb.size() > 0)) begin
            e = sb.pop_front();
            chk("ratio", 64'(o_ratio), 64'(e.ratio));
            chk("sat", 64'(o_sat), 64'(e.sat));
            chk("div0", 64'(o_div0), 64'(e.div0));
            chk("in0_byp", 64'(o_in0_byp), 64'(e.in0));
            chk("in1_byp", 64'(o_in1_byp), 64'(e.in1));
         end
      end
   endtask

   task automatic idle(int n);
      drive(1'b0, '0, '0, '0);
      repeat (n) step();
   endtask

   initial begin
      tv.push_back('{16'h0800, 16'h0400, 16'h0040, 16'h0020, 1'b0, 1'b0});
      tv.push_back('{16'h0600, 16'h0200, 16'h0040, 16'h0030, 1'b0, 1'b0});
      tv.push_back('{16'h0001, 16'hD800, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0});
      tv.push_back('{16'h0400, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0});
      tv.push_back('{16'h0000, 16'h0000, 16'h0040, 16'h7FFF, 1'b1, 1'b1});
      tv.push_back('{16'h8000, 16'h0000, 16'h0040, 16'h7FFF, 1'b1, 1'b1});
      tv.push_back('{16'h0400, 16'h0400, 16'h0001, 16'h0000, 1'b0, 1'b0});
      tv.push_back('{16'h0400, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0});
      tv.push_back('{16'h0400, 16'h0000, 16'h4000, 16'h4000, 1'b0, 1'b0});
      tv.push_back('{16'h0400, 16'hFC00, 16'h4000, 16'h7FFF, 1'b1, 1'b0});
      tv.push_back('{16'h0400, 16'h0000, 16'hFFC0, 16'h0000, 1'b0, 1'b0});

      i_rst = 1'b1; i_en = 1'b0;
      drive(1'b1, 16'h1234, 16'h0, 16'h0040);
      step();
      i_rst = 1'b0; i_en = 1'b1;
      idle(2);

      drive(1'b1, 16'h0400, 16'h0000, 16'h0040);
      step();
      idle(5);

      foreach (tv[i]) begin
         drive(1'b1, tv[i].in0, tv[i].lg, tv[i].in1);
         cur.ratio = tv[i].ratio; cur.sat = tv[i].sat; cur.div0 = tv[i].div0;
         step();
      end
      idle(4);

      drive(1'b1, 16'h0400, 16'h0000, 16'h0100); step();
      drive(1'b1, 16'h0200, 16'hFC00, 16'h0300); step();
      drive(1'b1, 16'h0C00, 16'h0600, 16'h0050); step();
      i_en = 1'b0;
      repeat (4) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
         step();
      end
      i_en = 1'b1;
      idle(5);

      for (int i = 0; i < 60; i++) begin
         i_en = $urandom_range(0, 3) != 0;
         drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 16'hFFFF)), 16'($urandom));
         step();
      end
      i_en = 1'b1;
      idle(5);

      drive(1'b1, 16'h0400, 16'h0000, 16'h0080); step();
      drive(1'b1, 16'h0400, 16'h0000, 16'h0200); step();
      i_rst = 1'b1;
      drive(1'b1, 16'h0400, 16'h0000, 16'h0300); step();
      i_rst = 1'b0;
      idle(5);
      drive(1'b1, 16'h0400, 16'h0000, 16'h0040); step();
      idle(5);

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
